gray_step_tracker: RTL

- Downstream consumer of the 3-bit gray counter stage. Samples the counter's gray code and overflow flag every clock and decodes them to binary.
- Checks that every change is a legal single +1 step, and extends the 3-bit count into a wide step count with wrap and step pulses.
- Latches a sticky error on any illegal transition. Feeds status and the extended count to the display and debug logic.

---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray_step_tracker_if.sv | 31 +++
 rtl/gray_decode.sv | 13 +
 rtl/gray_step_tracker.sv | 119 +++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the 3-bit gray counter stage and its consumers.
//   GRAY_W           width of the upstream gray code
//   INIT/TRACK/ERROR tracker state encodings (State output values)
//   gray2bin()       gray-to-binary conversion shared with the upstream counter
package gray_pkg;

   localparam int unsigned GRAY_W  = 3;
   localparam int unsigned STATE_W = 2;

   typedef logic [GRAY_W-1:0]  gray_t;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t INIT  = 2'd0;
   localparam state_t TRACK = 2'd1;
   localparam state_t ERROR = 2'd2;

   // Each binary bit is the XOR of all gray bits at and above it.
   function automatic gray_t gray2bin(input gray_t g);
      gray_t b;
      b[GRAY_W-1] = g[GRAY_W-1];
      for (int i = GRAY_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_step_tracker_if.sv
// Bus between the upstream gray counter / display side and gray_step_tracker.
//   master: drives Gray, GrayOvf, Clr; observes the tracker status outputs
//   slave : the tracker itself
interface gray_step_tracker_if
   import gray_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) ();

   gray_t             Gray;
   logic              GrayOvf;
   logic              Clr;
   gray_t             Bin;
   logic [CNT_W-1:0]  Count;
   logic              Step;
   logic              Wrap;
   logic              CntOvf;
   logic              Err;
   state_t            State;

   modport master (
      output Gray, GrayOvf, Clr,
      input  Bin, Count, Step, Wrap, CntOvf, Err, State
   );

   modport slave (
      input  Gray, GrayOvf, Clr,
      output Bin, Count, Step, Wrap, CntOvf, Err, State
   );

endinterface

// File: rtl/gray_decode.sv
// Purely combinational 3-bit gray to binary decoder.
//   Gray  input   gray code
//   Bin   output  binary equivalent
module gray_decode
   import gray_pkg::*;
(
   input  gray_t Gray,
   output gray_t Bin
);

   assign Bin = gray2bin(Gray);

endmodule

// File: rtl/gray_step_tracker.sv
// Samples the upstream gray counter every clock, checks that each change is a
// single legal +1 step, and extends it into a wide step count.
//   Clk    input  system clock, rising edge
//   Reset  input  asynchronous active-high reset
//   bus    slave  Gray/GrayOvf/Clr in; Bin/Count/Step/Wrap/CntOvf/Err/State out
module gray_step_tracker
   import gray_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input logic                 Clk,
   input logic                 Reset,
   gray_step_tracker_if.slave  bus
);

   gray_t             dec;
   state_t            state_q, state_d;
   // Bin doubles as the previously accepted value: it only diverges from the
   // last accepted step in ERROR, where the previous value no longer matters.
   gray_t             bin_q, bin_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              step_q, step_d;
   logic              wrap_q, wrap_d;
   logic              cntovf_q, cntovf_d;
   logic              err_q, err_d;

   gray_decode u_decode (
      .Gray (bus.Gray),
      .Bin  (dec)
   );

   gray_t bin_inc;
   logic  stall, fwd, at_top, ovf_rise, ovf_ok;

   assign bin_inc  = bin_q + gray_t'(1);
   assign stall    = (dec == bin_q);
   assign fwd      = (dec == bin_inc);
   assign at_top   = (bin_q == '1);
   assign ovf_rise = bus.GrayOvf & ~ovf_q;
   // Upstream overflow may only rise together with an accepted 7->0 step.
   assign ovf_ok   = ~ovf_rise | (fwd & at_top);

   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      ovf_d    = bus.GrayOvf;
      count_d  = count_q;
      step_d   = 1'b0;
      wrap_d   = 1'b0;
      cntovf_d = cntovf_q;
      err_d    = err_q;

      if (bus.Clr) begin
         state_d  = INIT;
         bin_d    = dec;
         count_d  = '0;
         cntovf_d = 1'b0;
         err_d    = 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               bin_d   = dec;
               state_d = TRACK;
            end
            TRACK: begin
               if (stall && ovf_ok) begin
                  // upstream stalled: hold
               end else if (fwd && ovf_ok) begin
                  step_d   = 1'b1;
                  wrap_d   = at_top;
                  bin_d    = dec;
                  count_d  = count_q + CNT_W'(1);
                  cntovf_d = cntovf_q | (count_q == '1);
               end else begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  bin_d   = dec;
               end
            end
            default: begin
               // ERROR and the unused encoding: only Bin follows the input
               bin_d = dec;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= INIT;
         bin_q    <= '0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
         step_q   <= 1'b0;
         wrap_q   <= 1'b0;
         cntovf_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         ovf_q    <= ovf_d;
         count_q  <= count_d;
         step_q   <= step_d;
         wrap_q   <= wrap_d;
         cntovf_q <= cntovf_d;
         err_q    <= err_d;
      end
   end

   assign bus.Bin    = bin_q;
   assign bus.Count  = count_q;
   assign bus.Step   = step_q;
   assign bus.Wrap   = wrap_q;
   assign bus.CntOvf = cntovf_q;
   assign bus.Err    = err_q;
   assign bus.State  = state_q;

endmodule
